multiplier: RTL and testbench
=============================

Name: multiplier

Overview:
- IEEE-754 single-precision floating-point multiplier. It is the companion arithmetic unit to the divider and uses the same stb/ack operand and result handshake.
- Multi-cycle FSM: it accepts operand a, then operand b, computes z = a*b with round-to-nearest-even, and presents z until it is acknowledged.
- Sits in the same datapath as the divider and sqrt blocks and can be swapped in wherever that handshake is used.

Parameters:
- none. Format is fixed at binary32: bias 127, 8-bit exponent, 23-bit fraction.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- input_a  in  32  operand a.
- input_a_stb  in  1  a valid.
- input_a_ack  out  1  ready for a. A transfer occurs on a rising edge where ack and stb are both 1.
- input_b  in  32  operand b.
- input_b_stb  in  1  b valid.
- input_b_ack  out  1  ready for b. Same transfer rule as a.
- output_z  out  32  product.
- output_z_stb  out  1  z valid.
- output_z_ack  in  1  consumer accepts z. A transfer occurs on an edge where stb and ack are both 1.

Behaviour:
- Reset (rst=0, asynchronous) forces: state=get_a, input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0.
  - Reset in any state aborts the operation; no partial result is ever emitted.
  - After release, input_a_ack rises on the first edge.
- States, in order: get_a, get_b, unpack, special_cases, normalise_a, normalise_b, multiply_0, multiply_1, normalise_1, normalise_2, round, pack, put_z.
- get_a / get_b:
  - Drive ack=1. On a transfer, latch the operand, drop ack on the same edge and advance.
  - input_b_ack is never 1 while the block is in get_a, and vice versa.
- unpack: split fields. Exponents are 10-bit signed, field minus 127. Mantissas are 24-bit.
- special_cases, checked in priority order, all going directly to put_z:
  - a or b NaN -> 0xFFC00000.
  - (a inf and b zero) or (b inf and a zero) -> 0xFFC00000.
  - a or b inf -> sign a_s^b_s, exponent 255, fraction 0.
  - a or b zero -> signed zero (a_s^b_s).
  - Otherwise:
    - A denormal operand (exponent -127) gets exponent -126 and hidden bit 0.
    - A normal operand gets hidden bit 1.
- normalise_a / normalise_b: while mantissa[23]==0, shift left one bit and decrement exponent, one bit per clock.
- multiply_0:
  - z_s = a_s^b_s.
  - z_e = a_e + b_e + 1 (10-bit signed; range -297..255 must not wrap).
  - product = a_m*b_m, 48-bit.
- multiply_1: z_m = product[47:24], guard = product[23], round_bit = product[22], sticky = |product[21:0].
- normalise_1: while z_m[23]==0 and z_e > -126, shift left one bit per clock:
  - z_m[0] <= guard; guard <= round_bit; round_bit <= 0; z_e decrements.
- normalise_2: while z_e < -126, shift right one bit per clock:
  - guard <= z_m[0]; round_bit <= guard; sticky |= round_bit; z_e increments.
- round:
  - If guard && (round_bit | sticky | z_m[0]), increment z_m.
  - If z_m was 0xFFFFFF before the increment, also increment z_e.
- pack:
  - Normal: exponent field = z_e+127.
  - z_e == -126 and z_m[23]==0 -> exponent field 0 (denormal).
  - z_e > 127 -> signed infinity, fraction 0.
- put_z:
  - Drive output_z and output_z_stb=1.
  - output_z is held stable while stb=1.
  - On a transfer, drop stb and return to get_a.
- Latency, counted from the b-transfer edge to the edge on which stb rises:
  - 11 clocks for normal operands needing no normalise_1 shift.
  - +1 per normalise shift (normalise_a/b, normalise_1, normalise_2).
  - 3 clocks for any special case.
- output_z_ack while stb=0 is ignored. The block is never back-to-back: a new a is accepted only after z is consumed.

Decomposition:
- Shared package float_pkg:
  - state encoding (4-bit)
  - BIAS=127
  - EXP_INF=128, EXP_DENORM=-127, EXP_MIN=-126, EXP_MAX=127
  - QNAN=32'hFFC00000
  - The same package is reused by the divider and sqrt blocks.
- No sub-module is needed; a single FSM module.

Test Plan:
- a=0x40000000 (2.0), b=0x40400000 (3.0) -> z=0x40C00000 (6.0). One normalise_1 shift, so stb rises 12 clocks after the b transfer.
- a=0x3FC00000, b=0x3FC00000 -> z=0x40100000 (2.25). No shift, stb rises after 11 clocks. Hold output_z_ack=0 for 5 clocks and check z and stb are stable, then ack and check stb drops and input_a_ack returns.
- Special cases:
  - a=0x7F800000, b=0x00000000 -> 0xFFC00000.
  - a=0xFF800000, b=0x40000000 -> 0xFF800000.
  - a=0x7FC00001, b=anything -> 0xFFC00000.
  - Each stb rises 3 clocks after the b transfer.
- Overflow and denormal:
  - a=0x7F7FFFFF, b=0x40000000 -> 0x7F800000.
  - a=0x00000001, b=0x3F800000 -> 0x00000001.
  - a=0x00800000, b=0x3F000000 -> 0x00400000.
- Rounding: a=0x3F800001, b=0x3F800001 -> 0x3F800002 (ties/sticky path).
- Reset in the middle of the operation: assert rst=0 during normalise_1 -> asynchronously stb=0, acks=0, output_z=0. Release, run a new operation 2.0*3.0 and check a clean 0x40C00000.

Source files
------------

// File: rtl/float_pkg.sv
// Shared binary32 definitions for the float arithmetic blocks (multiplier, divider, sqrt).
// Holds the FSM state encoding, exponent landmarks and the canonical quiet NaN.
package float_pkg;

  typedef enum logic [3:0] {
    GET_A         = 4'd0,
    GET_B         = 4'd1,
    UNPACK        = 4'd2,
    SPECIAL_CASES = 4'd3,
    NORMALISE_A   = 4'd4,
    NORMALISE_B   = 4'd5,
    MULTIPLY_0    = 4'd6,
    MULTIPLY_1    = 4'd7,
    NORMALISE_1   = 4'd8,
    NORMALISE_2   = 4'd9,
    ROUND         = 4'd10,
    PACK          = 4'd11,
    PUT_Z         = 4'd12
  } state_t;

  // Unbiased exponents are carried as 10-bit signed values so that the
  // product of two tiny denormals (down to -297) never wraps.
  localparam logic signed [9:0] BIAS       = 10'sd127;
  localparam logic signed [9:0] EXP_INF    = 10'sd128;
  localparam logic signed [9:0] EXP_DENORM = -10'sd127;
  localparam logic signed [9:0] EXP_MIN    = -10'sd126;
  localparam logic signed [9:0] EXP_MAX    = 10'sd127;

  localparam logic [31:0] QNAN = 32'hFFC00000;

  function automatic logic signed [9:0] unbiasExp(input logic [7:0] field);
    return $signed(10'(field)) - BIAS;
  endfunction

endpackage

// File: rtl/multiplier.sv
// IEEE-754 binary32 multiplier with stb/ack handshakes on a, b and z.
// One FSM walks unpack, special cases, normalise, multiply, round and pack.
module multiplier
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  state_t             state_q;
  logic [31:0]        a_q, b_q, z_q;
  logic [23:0]        a_m_q, b_m_q, z_m_q;
  logic signed [9:0]  a_e_q, b_e_q, z_e_q;
  logic               a_s_q, b_s_q, z_s_q;
  logic               guard_q, round_bit_q, sticky_q;
  logic [47:0]        product_q;
  logic               input_a_ack_q, input_b_ack_q, output_z_stb_q;
  logic [31:0]        output_z_q;

  logic               aNan, bNan, aInf, bInf, aZero, bZero;
  logic [7:0]         zExpField;

  assign aNan  = (a_e_q == EXP_INF) && (a_m_q != 24'd0);
  assign bNan  = (b_e_q == EXP_INF) && (b_m_q != 24'd0);
  assign aInf  = (a_e_q == EXP_INF) && (a_m_q == 24'd0);
  assign bInf  = (b_e_q == EXP_INF) && (b_m_q == 24'd0);
  assign aZero = (a_e_q == EXP_DENORM) && (a_m_q == 24'd0);
  assign bZero = (b_e_q == EXP_DENORM) && (b_m_q == 24'd0);

  assign zExpField = 8'(z_e_q + BIAS);

  assign input_a_ack  = input_a_ack_q;
  assign input_b_ack  = input_b_ack_q;
  assign output_z     = output_z_q;
  assign output_z_stb = output_z_stb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= GET_A;
      a_q            <= '0;
      b_q            <= '0;
      z_q            <= '0;
      a_m_q          <= '0;
      b_m_q          <= '0;
      z_m_q          <= '0;
      a_e_q          <= '0;
      b_e_q          <= '0;
      z_e_q          <= '0;
      a_s_q          <= 1'b0;
      b_s_q          <= 1'b0;
      z_s_q          <= 1'b0;
      guard_q        <= 1'b0;
      round_bit_q    <= 1'b0;
      sticky_q       <= 1'b0;
      product_q      <= '0;
      input_a_ack_q  <= 1'b0;
      input_b_ack_q  <= 1'b0;
      output_z_stb_q <= 1'b0;
      output_z_q     <= '0;
    end else begin
      unique case (state_q)
        GET_A: begin
          input_a_ack_q <= 1'b1;
          if (input_a_ack_q && input_a_stb) begin
            a_q           <= input_a;
            input_a_ack_q <= 1'b0;
            state_q       <= GET_B;
          end
        end

        GET_B: begin
          input_b_ack_q <= 1'b1;
          if (input_b_ack_q && input_b_stb) begin
            b_q           <= input_b;
            input_b_ack_q <= 1'b0;
            state_q       <= UNPACK;
          end
        end

        UNPACK: begin
          a_m_q   <= {1'b0, a_q[22:0]};
          b_m_q   <= {1'b0, b_q[22:0]};
          a_e_q   <= unbiasExp(a_q[30:23]);
          b_e_q   <= unbiasExp(b_q[30:23]);
          a_s_q   <= a_q[31];
          b_s_q   <= b_q[31];
          state_q <= SPECIAL_CASES;
        end

        // Priority matters: NaN beats inf*0, which beats plain inf, then zero.
        SPECIAL_CASES: begin
          if (aNan || bNan) begin
            z_q     <= QNAN;
            state_q <= PUT_Z;
          end else if ((aInf && bZero) || (bInf && aZero)) begin
            z_q     <= QNAN;
            state_q <= PUT_Z;
          end else if (aInf || bInf) begin
            z_q     <= {a_s_q ^ b_s_q, 8'hFF, 23'd0};
            state_q <= PUT_Z;
          end else if (aZero || bZero) begin
            z_q     <= {a_s_q ^ b_s_q, 31'd0};
            state_q <= PUT_Z;
          end else begin
            if (a_e_q == EXP_DENORM) a_e_q <= EXP_MIN;
            else                     a_m_q[23] <= 1'b1;
            if (b_e_q == EXP_DENORM) b_e_q <= EXP_MIN;
            else                     b_m_q[23] <= 1'b1;
            state_q <= NORMALISE_A;
          end
        end

        NORMALISE_A: begin
          if (a_m_q[23]) begin
            state_q <= NORMALISE_B;
          end else begin
            a_m_q <= a_m_q << 1;
            a_e_q <= a_e_q - 10'sd1;
          end
        end

        NORMALISE_B: begin
          if (b_m_q[23]) begin
            state_q <= MULTIPLY_0;
          end else begin
            b_m_q <= b_m_q << 1;
            b_e_q <= b_e_q - 10'sd1;
          end
        end

        MULTIPLY_0: begin
          z_s_q     <= a_s_q ^ b_s_q;
          z_e_q     <= a_e_q + b_e_q + 10'sd1;
          product_q <= 48'(a_m_q) * 48'(b_m_q);
          state_q   <= MULTIPLY_1;
        end

        MULTIPLY_1: begin
          z_m_q       <= product_q[47:24];
          guard_q     <= product_q[23];
          round_bit_q <= product_q[22];
          sticky_q    <= |product_q[21:0];
          state_q     <= NORMALISE_1;
        end

        NORMALISE_1: begin
          if (!z_m_q[23] && (z_e_q > EXP_MIN)) begin
            z_e_q       <= z_e_q - 10'sd1;
            z_m_q       <= {z_m_q[22:0], guard_q};
            guard_q     <= round_bit_q;
            round_bit_q <= 1'b0;
          end else begin
            state_q <= NORMALISE_2;
          end
        end

        // Results below the smallest normal exponent are denormalised here,
        // with shifted-out bits folding into guard/round/sticky.
        NORMALISE_2: begin
          if (z_e_q < EXP_MIN) begin
            z_e_q       <= z_e_q + 10'sd1;
            z_m_q       <= z_m_q >> 1;
            guard_q     <= z_m_q[0];
            round_bit_q <= guard_q;
            sticky_q    <= sticky_q | round_bit_q;
          end else begin
            state_q <= ROUND;
          end
        end

        ROUND: begin
          if (guard_q && (round_bit_q || sticky_q || z_m_q[0])) begin
            z_m_q <= z_m_q + 24'd1;
            if (z_m_q == 24'hFFFFFF) z_e_q <= z_e_q + 10'sd1;
          end
          state_q <= PACK;
        end

        PACK: begin
          z_q[31]    <= z_s_q;
          z_q[22:0]  <= z_m_q[22:0];
          z_q[30:23] <= zExpField;
          if ((z_e_q == EXP_MIN) && !z_m_q[23]) z_q[30:23] <= 8'd0;
          if (z_e_q > EXP_MAX) begin
            z_q[22:0]  <= 23'd0;
            z_q[30:23] <= 8'hFF;
          end
          state_q <= PUT_Z;
        end

        PUT_Z: begin
          output_z_stb_q <= 1'b1;
          output_z_q     <= z_q;
          if (output_z_stb_q && output_z_ack) begin
            output_z_stb_q <= 1'b0;
            state_q        <= GET_A;
          end
        end

        default: state_q <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Directed-vector bench for the binary32 multiplier: results, latency,
// output hold under backpressure, and asynchronous reset mid-operation.
module tb_multiplier;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int checkCount = 0;
  int passCount  = 0;

  multiplier dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Offer a then b; returns #1 after the b transfer edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    int n;
    input_a     = a;
    input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!input_a_ack) checkOutput("a_ack_timeout", 32'd0, 32'd1);
    checkOutput("b_ack_low_in_get_a", 32'(input_b_ack), 32'd0);
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    input_b     = b;
    input_b_stb = 1'b1;
    n = 0;
    while (!input_b_ack && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!input_b_ack) checkOutput("b_ack_timeout", 32'd0, 32'd1);
    checkOutput("a_ack_low_in_get_b", 32'(input_a_ack), 32'd0);
    @(posedge clk); #1;
    input_b_stb = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    int n;
    n = 0;
    while (!output_z_stb && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (!output_z_stb) checkOutput("z_stb_timeout", 32'd0, 32'd1);
    lat = n;
  endtask

  task automatic consume();
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
  endtask

  logic [31:0] vecA   [9];
  logic [31:0] vecB   [9];
  logic [31:0] vecZ   [9];
  int          vecLat [9];

  initial begin
    int lat;
    vecA   = '{32'h40000000, 32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h7F7FFFFF,
               32'h00000001, 32'h00800000, 32'h3F800001, 32'h80000000};
    vecB   = '{32'h40400000, 32'h00000000, 32'h40000000, 32'h3F800000, 32'h40000000,
               32'h3F800000, 32'h3F000000, 32'h3F800001, 32'h40000000};
    vecZ   = '{32'h40C00000, 32'hFFC00000, 32'hFF800000, 32'hFFC00000, 32'h7F800000,
               32'h00000001, 32'h00400000, 32'h3F800002, 32'h80000000};
    vecLat = '{12, 3, 3, 3, 12, 56, 11, 12, 3};

    rst          = 1'b0;
    input_a      = '0;
    input_b      = '0;
    input_a_stb  = 1'b0;
    input_b_stb  = 1'b0;
    output_z_ack = 1'b0;

    #12;
    checkOutput("rst_a_ack", 32'(input_a_ack), 32'd0);
    checkOutput("rst_b_ack", 32'(input_b_ack), 32'd0);
    checkOutput("rst_z_stb", 32'(output_z_stb), 32'd0);
    checkOutput("rst_z", output_z, 32'd0);

    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("a_ack_first_edge", 32'(input_a_ack), 32'd1);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecA[i], vecB[i]);
      waitResult(lat);
      checkOutput($sformatf("vec%0d_z", i), output_z, vecZ[i]);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecLat[i]));
      consume();
    end

    // Backpressure: z and stb must hold while the consumer stalls.
    applyStimulus(32'h3FC00000, 32'h3FC00000);
    waitResult(lat);
    checkOutput("hold_latency", 32'(lat), 32'd11);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold%0d_z", i), output_z, 32'h40100000);
      checkOutput($sformatf("hold%0d_stb", i), 32'(output_z_stb), 32'd1);
    end
    consume();
    checkOutput("stb_drop_after_ack", 32'(output_z_stb), 32'd0);
    @(posedge clk); #1;
    checkOutput("a_ack_after_consume", 32'(input_a_ack), 32'd1);

    // Ack while idle must not disturb the next operation.
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    checkOutput("idle_ack_no_stb", 32'(output_z_stb), 32'd0);

    // Reset while in normalise_1 (six edges after the b transfer for 2*3).
    applyStimulus(32'h40000000, 32'h40400000);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midrst_z", output_z, 32'd0);
    checkOutput("midrst_z_stb", 32'(output_z_stb), 32'd0);
    checkOutput("midrst_a_ack", 32'(input_a_ack), 32'd0);
    checkOutput("midrst_b_ack", 32'(input_b_ack), 32'd0);
    @(negedge clk) rst = 1'b1;

    applyStimulus(32'h40000000, 32'h40400000);
    waitResult(lat);
    checkOutput("post_rst_z", output_z, 32'h40C00000);
    checkOutput("post_rst_latency", 32'(lat), 32'd12);
    consume();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
